// File: rtl/gray_updown_counter_pkg.sv
// Shared types and mode constants for the up/down Gray counter family.
package gray_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam int MODE_WRAP     = 0;
    localparam int MODE_SATURATE = 1;

endpackage : gray_pkg

// File: rtl/gray_updown_counter_if.sv
// Control/status bundle of the up/down Gray counter; the counter is the slave side.
interface gray_updown_counter_if #(
    parameter int P_WIDTH = 4
);
    logic               CLR;
    logic               EN;
    logic               DIR;
    logic               LOAD;
    logic [P_WIDTH-1:0] LOAD_VALUE;
    logic [P_WIDTH-1:0] COUNT;
    logic [P_WIDTH-1:0] COUNT_BIN;
    logic               LIMIT;

    modport master (
        output CLR, EN, DIR, LOAD, LOAD_VALUE,
        input  COUNT, COUNT_BIN, LIMIT
    );

    modport slave (
        input  CLR, EN, DIR, LOAD, LOAD_VALUE,
        output COUNT, COUNT_BIN, LIMIT
    );
endinterface : gray_updown_counter_if

// File: rtl/gray_updown_counter_gray_to_bin.sv
// Combinational Gray-to-binary conversion: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
    parameter int P_WIDTH = 4
) (
    input  logic [P_WIDTH-1:0] gray,
    output logic [P_WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int unsigned i = 0; i < P_WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule : gray_to_bin

// File: rtl/gray_updown_counter.sv
// Up/down Gray counter with load, clear, wrap/saturate limit handling and a registered binary shadow.
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int                 P_WIDTH     = 4,
    parameter int                 P_SATURATE  = MODE_WRAP,
    parameter logic [P_WIDTH-1:0] P_INIT_GRAY = '0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    gray_updown_counter_if.slave  bus
);

    function automatic logic [P_WIDTH-1:0] gray2bin(input logic [P_WIDTH-1:0] g);
        logic [P_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < P_WIDTH; i++) begin
            r[i] = ^(g >> i);
        end
        return r;
    endfunction

    localparam logic [P_WIDTH-1:0] INIT_BIN = gray2bin(P_INIT_GRAY);
    localparam logic [P_WIDTH:0]   STEP_ONE = (P_WIDTH + 1)'(1);
    localparam bit                 SAT_MODE = (P_SATURATE == MODE_SATURATE);

    logic [P_WIDTH-1:0] b_q;
    logic [P_WIDTH-1:0] count_q;
    logic               limit_q;

    logic [P_WIDTH-1:0] load_bin;
    logic [P_WIDTH-1:0] next_b;
    logic               next_limit;
    logic [P_WIDTH:0]   step_ext;
    dir_e               dir;

    gray_to_bin #(.P_WIDTH(P_WIDTH)) u_load_conv (
        .gray (bus.LOAD_VALUE),
        .bin  (load_bin)
    );

    // The extra MSB of the widened step is the carry (up) or borrow (down),
    // which is exactly "b was at the limit for this direction".
    always_comb begin
        dir        = dir_e'(bus.DIR);
        step_ext   = (dir == DIR_UP) ? ({1'b0, b_q} + STEP_ONE) : ({1'b0, b_q} - STEP_ONE);
        next_b     = b_q;
        next_limit = 1'b0;
        if (bus.CLR) begin
            next_b = INIT_BIN;
        end else if (bus.LOAD) begin
            next_b = load_bin;
        end else if (bus.EN) begin
            next_limit = step_ext[P_WIDTH];
            if (!(step_ext[P_WIDTH] && SAT_MODE)) begin
                next_b = step_ext[P_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            b_q     <= INIT_BIN;
            count_q <= P_INIT_GRAY;
            limit_q <= 1'b0;
        end else begin
            b_q     <= next_b;
            count_q <= next_b ^ (next_b >> 1);
            limit_q <= next_limit;
        end
    end

    assign bus.COUNT     = count_q;
    assign bus.COUNT_BIN = b_q;
    assign bus.LIMIT     = limit_q;

endmodule : gray_updown_counter

// File: tb/tb_gray_updown_counter.sv
// Directed and random scoreboard bench for three counter configurations: 4-bit wrap, 4-bit saturate (init 3), 12-bit wrap.
module tb_gray_updown_counter;
    import gray_pkg::*;

    typedef struct {
        int    id;
        int    count;
        int    bin;
        int    limit;
        string tag;
    } exp_t;

    logic CLK = 1'b0;
    logic rst_n_a, rst_n_s, rst_n_w;

    int n_assert = 0;
    int n_fail   = 0;
    exp_t sb[$];

    // per-instance reference model state: 0 = wrap4, 1 = sat4, 2 = wide12
    int mb[3];
    int wid[3]   = '{4, 4, 12};
    int satm[3]  = '{0, 1, 0};
    int initb[3] = '{0, 2, 0};

    gray_updown_counter_if #(.P_WIDTH(4))  ifa ();
    gray_updown_counter_if #(.P_WIDTH(4))  ifs ();
    gray_updown_counter_if #(.P_WIDTH(12)) ifw ();

    gray_updown_counter #(.P_WIDTH(4), .P_SATURATE(MODE_WRAP), .P_INIT_GRAY(4'h0)) dut_wrap (
        .CLK(CLK), .RST_N(rst_n_a), .bus(ifa));
    gray_updown_counter #(.P_WIDTH(4), .P_SATURATE(MODE_SATURATE), .P_INIT_GRAY(4'h3)) dut_sat (
        .CLK(CLK), .RST_N(rst_n_s), .bus(ifs));
    gray_updown_counter #(.P_WIDTH(12), .P_SATURATE(MODE_WRAP), .P_INIT_GRAY(12'h000)) dut_wide (
        .CLK(CLK), .RST_N(rst_n_w), .bus(ifw));

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int g2b(input int g, input int w);
        int r = 0;
        int acc = 0;
        for (int i = w - 1; i >= 0; i--) begin
            acc ^= (g >> i) & 1;
            r |= acc << i;
        end
        return r;
    endfunction

    function automatic int obs_count(input int id);
        case (id)
            0:       return int'(ifa.COUNT);
            1:       return int'(ifs.COUNT);
            default: return int'(ifw.COUNT);
        endcase
    endfunction

    function automatic int obs_bin(input int id);
        case (id)
            0:       return int'(ifa.COUNT_BIN);
            1:       return int'(ifs.COUNT_BIN);
            default: return int'(ifw.COUNT_BIN);
        endcase
    endfunction

    function automatic int obs_limit(input int id);
        case (id)
            0:       return int'(ifa.LIMIT);
            1:       return int'(ifs.LIMIT);
            default: return int'(ifw.LIMIT);
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int id, input bit clr, input bit load, input int lv, input bit en, input bit dir);
        case (id)
            0: begin
                ifa.CLR = clr; ifa.LOAD = load; ifa.LOAD_VALUE = 4'(lv); ifa.EN = en; ifa.DIR = dir;
            end
            1: begin
                ifs.CLR = clr; ifs.LOAD = load; ifs.LOAD_VALUE = 4'(lv); ifs.EN = en; ifs.DIR = dir;
            end
            default: begin
                ifw.CLR = clr; ifw.LOAD = load; ifw.LOAD_VALUE = 12'(lv); ifw.EN = en; ifw.DIR = dir;
            end
        endcase
    endtask

    // Drive one cycle, predict into the scoreboard, clock, then pop and compare.
    task automatic step(input int id, input bit clr, input bit load, input int lv,
                        input bit en, input bit dir, input string tag, output int cnt);
        int   maxv, b, nb, lim;
        exp_t e, got;
        drive(id, clr, load, lv, en, dir);
        maxv = (1 << wid[id]) - 1;
        b    = mb[id];
        nb   = b;
        lim  = 0;
        if (clr) nb = initb[id];
        else if (load) nb = g2b(lv, wid[id]);
        else if (en) begin
            if (dir) begin
                if (b == maxv) begin lim = 1; nb = satm[id] ? b : 0; end
                else nb = b + 1;
            end else begin
                if (b == 0) begin lim = 1; nb = satm[id] ? 0 : maxv; end
                else nb = b - 1;
            end
        end
        mb[id]  = nb;
        e.id    = id;
        e.count = nb ^ (nb >> 1);
        e.bin   = nb;
        e.limit = lim;
        e.tag   = tag;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        got = sb.pop_front();
        cnt = obs_count(got.id);
        check({got.tag, "_count"}, cnt, got.count);
        check({got.tag, "_bin"}, obs_bin(got.id), got.bin);
        check({got.tag, "_limit"}, obs_limit(got.id), got.limit);
        drive(id, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic reset_unit(input int id);
        case (id)
            0:       rst_n_a = 1'b0;
            1:       rst_n_s = 1'b0;
            default: rst_n_w = 1'b0;
        endcase
        @(posedge CLK);
        #1;
        case (id)
            0:       rst_n_a = 1'b1;
            1:       rst_n_s = 1'b1;
            default: rst_n_w = 1'b1;
        endcase
        mb[id] = initb[id];
    endtask

    initial begin
        int cnt, prev;
        bit clr, load, en;
        rst_n_a = 1'b0; rst_n_s = 1'b0; rst_n_w = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        check("rst_wrap_count", obs_count(0), 0);
        check("rst_wrap_limit", obs_limit(0), 0);
        check("rst_sat_count", obs_count(1), 3);
        check("rst_sat_bin", obs_bin(1), 2);
        check("rst_wide_count", obs_count(2), 0);
        rst_n_a = 1'b1; rst_n_s = 1'b1; rst_n_w = 1'b1;
        for (int i = 0; i < 3; i++) mb[i] = initb[i];

        // count up through the wrap, one-bit changes throughout
        prev = 0;
        for (int i = 0; i < 17; i++) begin
            step(0, 1'b0, 1'b0, 0, 1'b1, 1'b1, "up", cnt);
            check("up_hamming", $countones(prev ^ cnt), 1);
            prev = cnt;
        end

        // count down from reset, reverse direction at BIN 14
        reset_unit(0);
        step(0, 1'b0, 1'b0, 0, 1'b1, 1'b0, "down_wrap", cnt);
        step(0, 1'b0, 1'b0, 0, 1'b1, 1'b0, "down_14", cnt);
        step(0, 1'b0, 1'b0, 0, 1'b1, 1'b1, "dir_flip", cnt);
        step(0, 1'b0, 1'b0, 0, 1'b0, 1'b1, "hold", cnt);

        // saturate up and down
        step(1, 1'b0, 1'b1, 4'h9, 1'b0, 1'b1, "sat_load", cnt);
        for (int i = 0; i < 3; i++) step(1, 1'b0, 1'b0, 0, 1'b1, 1'b1, "sat_up", cnt);
        step(1, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, "load_over_en", cnt);
        for (int i = 0; i < 2; i++) step(1, 1'b0, 1'b0, 0, 1'b1, 1'b0, "sat_down", cnt);

        // priority: LOAD beats EN, CLR beats LOAD
        step(1, 1'b0, 1'b1, 4'hA, 1'b1, 1'b1, "load_a", cnt);
        step(1, 1'b1, 1'b1, 4'hA, 1'b1, 1'b1, "clr_prio", cnt);

        // asynchronous reset mid-cycle with EN high
        step(1, 1'b0, 1'b1, 4'hD, 1'b0, 1'b1, "load_d", cnt);
        drive(1, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        #2;
        rst_n_s = 1'b0;
        #1;
        check("async_count", obs_count(1), 3);
        check("async_bin", obs_bin(1), 2);
        check("async_limit", obs_limit(1), 0);
        @(posedge CLK);
        #3;
        rst_n_s = 1'b1;
        mb[1] = initb[1];
        step(1, 1'b0, 1'b0, 0, 1'b1, 1'b1, "post_rst", cnt);

        // wide random run against the model
        prev = obs_count(2);
        for (int i = 0; i < 10000; i++) begin
            clr  = ($urandom_range(0, 63) == 0);
            load = ($urandom_range(0, 15) == 0);
            en   = $urandom_range(0, 1) != 0;
            step(2, clr, load, int'($urandom_range(0, 4095)), en, $urandom_range(0, 1) != 0, "wide", cnt);
            if (!clr && !load && en) check("wide_hamming", $countones(prev ^ cnt), 1);
            prev = cnt;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_gray_updown_counter
